fp_pair_serializer: RTL and testbench



---
 rtl/fp_pair_serializer.sv | 118 +++++++++++
 tb/tb_fp_pair_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_pair_serializer.sv
// Buffers floating-point operand pairs and sends each one out as two operands, A then B,
// over a valid/ready stream. All outputs come from registered state through a 2:1 mux.
module fp_pair_serializer #(
    parameter int DEPTH = 4,
    parameter int MW    = 24,
    parameter int EW    = 8
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [MW-1:0]            A1,
    input  logic [MW-1:0]            B1,
    input  logic [EW-1:0]            AE1,
    input  logic [EW-1:0]            BE1,
    input  logic                     AS1,
    input  logic                     BS1,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [MW-1:0]            OM,
    output logic [EW-1:0]            OE,
    output logic                     OS,
    output logic                     OSEL,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [MW-1:0] am;
        logic [EW-1:0] ae;
        logic          a_s;
        logic [MW-1:0] bm;
        logic [EW-1:0] be;
        logic          b_s;
    } pair_t;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    pair_t          mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [CW-1:0]  cnt;
    phase_t         ph;
    phase_t         ph_next;
    pair_t          head;
    logic           push;
    logic           xfer;
    logic           pop;

    // Full blocks input even when a pop happens in the same cycle.
    assign IN_READY  = (cnt != CW'(DEPTH));
    assign OUT_VALID = (cnt != '0);
    assign push      = IN_VALID && IN_READY;
    assign xfer      = OUT_VALID && OUT_READY;
    assign pop       = xfer && (ph == PH_B);
    assign LEVEL     = cnt;

    always_comb begin
        ph_next = ph;
        if (xfer) begin
            ph_next = (ph == PH_A) ? PH_B : PH_A;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ph  <= PH_A;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            ph <= ph_next;
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // While non-empty and not full, wp never equals rp, so a push cannot touch the head.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wp] <= '{am: A1, ae: AE1, a_s: AS1, bm: B1, be: BE1, b_s: BS1};
        end
    end

    assign head = mem[rp];

    always_comb begin
        OM   = head.am;
        OE   = head.ae;
        OS   = head.a_s;
        OSEL = 1'b0;
        if (ph == PH_B) begin
            OM   = head.bm;
            OE   = head.be;
            OS   = head.b_s;
            OSEL = 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_pair_serializer.sv
// Directed bench for fp_pair_serializer: a vector table for the basic and fill/drain
// behaviour, then hand-written sequences for backpressure, full+pop, streaming and async reset.
module tb_fp_pair_serializer;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [23:0] A1 = '0;
    logic [23:0] B1 = '0;
    logic [7:0]  AE1 = '0;
    logic [7:0]  BE1 = '0;
    logic        AS1 = 1'b0;
    logic        BS1 = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [23:0] OM;
    logic [7:0]  OE;
    logic        OS;
    logic        OSEL;
    logic [2:0]  LEVEL;

    always #5 CLK = ~CLK;

    fp_pair_serializer #(.DEPTH(4), .MW(24), .EW(8)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A1(A1), .B1(B1), .AE1(AE1), .BE1(BE1), .AS1(AS1), .BS1(BS1),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OM(OM), .OE(OE), .OS(OS), .OSEL(OSEL), .LEVEL(LEVEL)
    );

    typedef struct {
        logic [23:0] am;
        logic [7:0]  ae;
        logic        a_s;
        logic [23:0] bm;
        logic [7:0]  be;
        logic        b_s;
    } pair_t;

    typedef struct {
        logic  iv;
        pair_t p;
        logic  ordy;
        logic  x_ir;
        logic  x_ov;
        logic  x_chk;
        pair_t xp;
        logic  x_sel;
        int    x_lvl;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input pair_t p, input logic ordy);
        IN_VALID  = iv;
        A1        = p.am;
        AE1       = p.ae;
        AS1       = p.a_s;
        B1        = p.bm;
        BE1       = p.be;
        BS1       = p.b_s;
        OUT_READY = ordy;
    endtask

    task automatic checkOperand(input string tag, input pair_t xp, input logic sel, input int lvl);
        checkOutput({tag, " out_valid"}, 32'(OUT_VALID), 32'd1);
        checkOutput({tag, " osel"}, 32'(OSEL), 32'(sel));
        checkOutput({tag, " om"}, 32'(OM), 32'(sel ? xp.bm : xp.am));
        checkOutput({tag, " oe"}, 32'(OE), 32'(sel ? xp.be : xp.ae));
        checkOutput({tag, " os"}, 32'(OS), 32'(sel ? xp.b_s : xp.a_s));
        checkOutput({tag, " level"}, 32'(LEVEL), 32'(lvl));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, " out_valid"}, 32'(OUT_VALID), 32'd0);
        checkOutput({tag, " level"}, 32'(LEVEL), 32'd0);
        checkOutput({tag, " in_ready"}, 32'(IN_READY), 32'd1);
    endtask

    task automatic add_vec(input logic iv, input pair_t p, input logic ordy, input logic x_ir,
                           input logic x_ov, input logic x_chk, input pair_t xp,
                           input logic x_sel, input int x_lvl);
        vec_t v;
        v.iv = iv; v.p = p; v.ordy = ordy; v.x_ir = x_ir; v.x_ov = x_ov;
        v.x_chk = x_chk; v.xp = xp; v.x_sel = x_sel; v.x_lvl = x_lvl;
        tbl.push_back(v);
    endtask

    function automatic pair_t mkpair(input int k);
        pair_t p;
        p.am  = 24'(32'h00A000 + k * 32'h010203);
        p.ae  = 8'(k * 3 + 1);
        p.a_s = k[0];
        p.bm  = 24'(32'hF00000 - k * 32'h000457);
        p.be  = 8'(32'hF0 - k);
        p.b_s = ~k[0];
        return p;
    endfunction

    initial begin
        pair_t z, p0, q1, q2, q3, q4, q5, w;
        z  = '{am: 24'h0, ae: 8'h0, a_s: 1'b0, bm: 24'h0, be: 8'h0, b_s: 1'b0};
        p0 = '{am: 24'h800000, ae: 8'h7F, a_s: 1'b0, bm: 24'hC00000, be: 8'h80, b_s: 1'b1};
        q1 = '{am: 24'h123456, ae: 8'h01, a_s: 1'b0, bm: 24'h654321, be: 8'h02, b_s: 1'b1};
        q2 = '{am: 24'hABCDEF, ae: 8'h10, a_s: 1'b1, bm: 24'h000001, be: 8'hFF, b_s: 1'b0};
        q3 = '{am: 24'hFFFFFF, ae: 8'h00, a_s: 1'b1, bm: 24'h7FFFFF, be: 8'hFE, b_s: 1'b1};
        q4 = '{am: 24'h0F0F0F, ae: 8'h55, a_s: 1'b0, bm: 24'hF0F0F0, be: 8'hAA, b_s: 1'b0};
        q5 = '{am: 24'hDEAD00, ae: 8'h33, a_s: 1'b1, bm: 24'hBEEF00, be: 8'h44, b_s: 1'b1};

        // Single pair, then fill to full with a rejected fifth pair, then drain.
        add_vec(1, p0, 1, 1, 0, 1, z,  0, 0);
        add_vec(0, z,  1, 1, 1, 1, p0, 0, 1);
        add_vec(0, z,  1, 1, 1, 1, p0, 1, 1);
        add_vec(0, z,  0, 1, 0, 0, z,  0, 0);
        add_vec(1, q1, 0, 1, 0, 0, z,  0, 0);
        add_vec(1, q2, 0, 1, 1, 1, q1, 0, 1);
        add_vec(1, q3, 0, 1, 1, 1, q1, 0, 2);
        add_vec(1, q4, 0, 1, 1, 1, q1, 0, 3);
        add_vec(1, q5, 0, 0, 1, 1, q1, 0, 4);
        add_vec(1, q5, 1, 0, 1, 1, q1, 0, 4);
        add_vec(0, z,  1, 0, 1, 1, q1, 1, 4);
        add_vec(0, z,  1, 1, 1, 1, q2, 0, 3);
        add_vec(0, z,  1, 1, 1, 1, q2, 1, 3);
        add_vec(0, z,  1, 1, 1, 1, q3, 0, 2);
        add_vec(0, z,  1, 1, 1, 1, q3, 1, 2);
        add_vec(0, z,  1, 1, 1, 1, q4, 0, 1);
        add_vec(0, z,  1, 1, 1, 1, q4, 1, 1);
        add_vec(0, z,  0, 1, 0, 0, z,  0, 0);

        #12;
        checkEmpty("reset");
        checkOutput("reset om", 32'(OM), 32'd0);
        checkOutput("reset osel", 32'(OSEL), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        foreach (tbl[i]) begin
            @(negedge CLK);
            applyStimulus(tbl[i].iv, tbl[i].p, tbl[i].ordy);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), 32'(IN_READY), 32'(tbl[i].x_ir));
            checkOutput($sformatf("vec%0d out_valid", i), 32'(OUT_VALID), 32'(tbl[i].x_ov));
            checkOutput($sformatf("vec%0d level", i), 32'(LEVEL), 32'(tbl[i].x_lvl));
            if (tbl[i].x_chk) begin
                checkOutput($sformatf("vec%0d osel", i), 32'(OSEL), 32'(tbl[i].x_sel));
                checkOutput($sformatf("vec%0d om", i), 32'(OM),
                            32'(tbl[i].x_sel ? tbl[i].xp.bm : tbl[i].xp.am));
                checkOutput($sformatf("vec%0d oe", i), 32'(OE),
                            32'(tbl[i].x_sel ? tbl[i].xp.be : tbl[i].xp.ae));
                checkOutput($sformatf("vec%0d os", i), 32'(OS),
                            32'(tbl[i].x_sel ? tbl[i].xp.b_s : tbl[i].xp.a_s));
            end
        end

        // Backpressure on the B phase while a second pair is pushed behind the head.
        @(negedge CLK); applyStimulus(1, mkpair(10), 0); #1; checkEmpty("bp start");
        @(negedge CLK); applyStimulus(0, z, 1);          #1; checkOperand("bp A", mkpair(10), 0, 1);
        @(negedge CLK); applyStimulus(1, mkpair(11), 0); #1; checkOperand("bp B", mkpair(10), 1, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); applyStimulus(0, z, 0); #1;
            checkOperand($sformatf("bp hold%0d", k), mkpair(10), 1, 2);
        end
        @(negedge CLK); applyStimulus(0, z, 1); #1; checkOperand("bp drain0", mkpair(10), 1, 2);
        @(negedge CLK); #1; checkOperand("bp drain1", mkpair(11), 0, 1);
        @(negedge CLK); #1; checkOperand("bp drain2", mkpair(11), 1, 1);
        @(negedge CLK); applyStimulus(0, z, 0); #1; checkEmpty("bp end");

        // Full with a pop in the same cycle: the push must wait one cycle.
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); applyStimulus(1, mkpair(20 + k), 0); #1;
            checkOutput($sformatf("full fill%0d level", k), 32'(LEVEL), 32'(k));
        end
        @(negedge CLK); applyStimulus(0, z, 1); #1;
        checkOperand("full A0", mkpair(20), 0, 4);
        checkOutput("full A0 in_ready", 32'(IN_READY), 32'd0);
        @(negedge CLK); applyStimulus(1, mkpair(24), 1); #1;
        checkOperand("full B0", mkpair(20), 1, 4);
        checkOutput("full pop in_ready", 32'(IN_READY), 32'd0);
        @(negedge CLK); applyStimulus(1, mkpair(24), 0); #1;
        checkOperand("full after pop", mkpair(21), 0, 3);
        checkOutput("full retry in_ready", 32'(IN_READY), 32'd1);
        @(negedge CLK); applyStimulus(0, z, 1); #1;
        checkOperand("full refilled", mkpair(21), 0, 4);
        for (int n = 1; n < 8; n++) begin
            @(negedge CLK); #1;
            checkOperand($sformatf("full drain%0d", n), mkpair(21 + n / 2), 1'(n % 2), 4 - n / 2);
        end
        @(negedge CLK); applyStimulus(0, z, 0); #1; checkEmpty("full end");

        // Streaming 20 pairs at one pair per two cycles, wrapping the pointers.
        for (int t = 0; t < 42; t++) begin
            @(negedge CLK);
            applyStimulus((t % 2 == 0) && (t < 40), mkpair(100 + t / 2), 1);
            #1;
            if (t == 0 || t == 41) begin
                checkEmpty($sformatf("stream t%0d", t));
            end else begin
                checkOperand($sformatf("stream t%0d", t), mkpair(100 + (t - 1) / 2), 1'((t - 1) % 2), 1);
            end
        end

        // Asynchronous reset mid-cycle while B of the head pair is pending.
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); applyStimulus(1, mkpair(30 + k), 0);
        end
        @(negedge CLK); applyStimulus(0, z, 1);
        @(negedge CLK); applyStimulus(0, z, 0); #1;
        checkOperand("arst before", mkpair(30), 1, 3);
        #2 RSTN = 1'b0;
        #1;
        checkEmpty("arst during");
        checkOutput("arst osel", 32'(OSEL), 32'd0);
        checkOutput("arst om", 32'(OM), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        w = mkpair(40);
        applyStimulus(1, w, 0); #1; checkEmpty("arst release");
        @(negedge CLK); applyStimulus(0, z, 1); #1; checkOperand("arst A", w, 0, 1);
        @(negedge CLK); #1; checkOperand("arst B", w, 1, 1);
        @(negedge CLK); applyStimulus(0, z, 0); #1; checkEmpty("arst end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
